// File: rtl/finv_table_writer.sv
// finv_table_writer: assembles a big-endian byte stream into DATA_W-bit entries and writes them
// to the finv table RAM in ascending address order. Define FINV_TABLE_CHECKSUM_EN for a trailing XOR checksum byte.
module finv_table_writer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 36
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int NBYTES = (DATA_W + 7) / 8;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

`ifdef FINV_TABLE_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, LOAD, CHECK, FIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, FIN} state_t;
`endif

    state_t              state;
    logic [BCW-1:0]      byte_cnt;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-9:0]   acc;
    logic [DATA_W-1:0]   word;
    logic                hs;

    assign hs = in_valid && in_ready;
    // Keeping only DATA_W bits of the shifted stream drops the unused high bits of the first byte.
    assign word = {acc, in_data};

`ifdef FINV_TABLE_CHECKSUM_EN
    logic [7:0] csum;
    logic       err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            byte_cnt <= '0;
            addr     <= '0;
            acc      <= '0;
`ifdef FINV_TABLE_CHECKSUM_EN
            csum     <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    byte_cnt <= '0;
                    addr     <= '0;
                    acc      <= '0;
`ifdef FINV_TABLE_CHECKSUM_EN
                    csum     <= '0;
`endif
                    if (start) begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
`ifdef FINV_TABLE_CHECKSUM_EN
                        err_q    <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (hs) begin
                        acc <= word[DATA_W-9:0];
`ifdef FINV_TABLE_CHECKSUM_EN
                        csum <= csum ^ in_data;
`endif
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                            wr_en    <= 1'b1;
                            wr_addr  <= addr;
                            wr_data  <= word;
                            addr     <= addr + 1'b1;
                            if (&addr) begin
`ifdef FINV_TABLE_CHECKSUM_EN
                                state    <= CHECK;
`else
                                state    <= FIN;
                                in_ready <= 1'b0;
                                done     <= 1'b1;
`endif
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                    // A word completed on this same cycle still gets its write; only the FSM is cancelled.
                    if (abort) begin
                        state    <= IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b0;
                    end
                end
`ifdef FINV_TABLE_CHECKSUM_EN
                CHECK: begin
                    if (abort) begin
                        state    <= IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                    end else if (hs) begin
                        err_q    <= (in_data != csum);
                        state    <= FIN;
                        in_ready <= 1'b0;
                        done     <= 1'b1;
                    end
                end
`endif
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_finv_table_writer.sv
// Directed self-checking bench for finv_table_writer (default 1024 x 36 geometry).
module tb_finv_table_writer;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 36;
    localparam int N      = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst, start, abort, in_valid;
    logic [7:0]        in_data;
    logic              in_ready, wr_en, busy, done, err;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic last_err = 1'b0;
    logic [ADDR_W-1:0] wa_q[$];
    logic [DATA_W-1:0] wd_q[$];
    int                wc_q[$];

    finv_table_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            wc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            last_err = err;
        end
    end

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        done_cnt = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
    endtask

    // Presents a byte and holds it until a handshake edge; returns just after that edge.
    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        int t;
        ok = 1'b1;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL handshake_timeout in_ready=%b required 1", in_ready);
            ok = 1'b0;
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; abort = 1'b0; in_valid = 1'b1; in_data = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
        checks++; if (wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr got %h exp 0", wr_addr); end
        checks++; if (wr_data !== '0) begin errors++; $display("FAIL reset_wr_data got %h exp 0", wr_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        #1;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_full_load(input string name, input bit gappy, input bit corrupt);
        bit ok;
        logic [15:0] kk;
        logic [7:0]  b, xr;
        int c0, c1, nbad, first_bad, t;
        logic exp_err;
        int hs_q[$];
        $display("full load %s gappy=%0b corrupt=%0b", name, gappy, corrupt);
        clear_mon();
        xr = 8'h00; c0 = 0; c1 = 0; ok = 1'b1;
        do_start();
        for (int k = 0; k < N && ok; k++) begin
            kk = 16'(k);
            for (int j = 0; j < 5 && ok; j++) begin
                b = (j == 3) ? kk[15:8] : (j == 4) ? kk[7:0] : 8'h00;
                send_byte(b, gappy ? int'($urandom_range(0, 1)) : 0, ok);
                xr = xr ^ b;
                if (k == 0 && j == 0) c0 = cyc;
                if (j == 4) hs_q.push_back(cyc);
                c1 = cyc;
            end
        end
        exp_err = 1'b0;
`ifdef FINV_TABLE_CHECKSUM_EN
        exp_err = corrupt;
        if (ok) send_byte(xr ^ {7'b0, corrupt}, 0, ok);
`endif
        t = 0;
        while (done_cnt == 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        checks++; if (wa_q.size() != N) begin errors++; $display("FAIL %s_write_count got %0d exp %0d", name, wa_q.size(), N); end
        nbad = 0; first_bad = -1;
        for (int i = 0; i < wa_q.size() && i < N; i++) begin
            if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== DATA_W'(i) || i >= hs_q.size() || wc_q[i] != hs_q[i]) begin
                nbad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL %s_entries bad=%0d first=%0d addr=%h data=%h wcyc=%0d exp addr=%h data=%h hscyc=%0d",
                     name, nbad, first_bad, wa_q[first_bad], wd_q[first_bad], wc_q[first_bad],
                     ADDR_W'(first_bad), DATA_W'(first_bad), (first_bad < hs_q.size()) ? hs_q[first_bad] : -1);
        end
        if (!gappy) begin
            checks++; if (c1 - c0 != 5 * N - 1) begin errors++; $display("FAIL %s_throughput got %0d cycles exp %0d", name, c1 - c0, 5 * N - 1); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s_done_count got %0d exp 1", name, done_cnt); end
        checks++; if (last_err !== exp_err) begin errors++; $display("FAIL %s_err got %b exp %b", name, last_err, exp_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_after got %b exp 0", name, busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s_ready_after got %b exp 0", name, in_ready); end
    endtask

    task automatic test_upper_nibble();
        bit ok;
        logic [7:0] bytes[5] = '{8'hFA, 8'h12, 8'h34, 8'h56, 8'h78};
        clear_mon();
        do_start();
        for (int j = 0; j < 5; j++) send_byte(bytes[j], 0, ok);
        @(negedge clk);
        checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL nibble_wr_en got %b exp 1", wr_en); end
        checks++; if (wr_addr !== '0) begin errors++; $display("FAIL nibble_wr_addr got %h exp 0", wr_addr); end
        checks++; if (wr_data !== 36'hA_1234_5678) begin errors++; $display("FAIL nibble_wr_data got %h exp a12345678", wr_data); end
        #1;
        do_abort();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_abort();
        bit ok;
        logic [7:0] bytes[7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h11, 8'h22};
        clear_mon();
        do_start();
        for (int j = 0; j < 7; j++) send_byte(bytes[j], 0, ok);
        do_abort();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got %b exp 0", in_ready); end
        repeat (3) @(negedge clk);
        checks++; if (wa_q.size() != 1) begin errors++; $display("FAIL abort_write_count got %0d exp 1", wa_q.size()); end
        if (wa_q.size() >= 1) begin
            checks++;
            if (wa_q[0] !== '0 || wd_q[0] !== 36'd5) begin
                errors++; $display("FAIL abort_entry got addr=%h data=%h exp addr=0 data=5", wa_q[0], wd_q[0]);
            end
        end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_done got %0d exp 0", done_cnt); end
        #1;
        clear_mon();
        do_start();
        for (int j = 0; j < 4; j++) send_byte(8'h00, 0, ok);
        send_byte(8'h09, 0, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (wa_q.size() != 1 || wa_q[0] !== '0 || wd_q[0] !== 36'd9) begin
            errors++; $display("FAIL restart_entry got n=%0d addr=%h data=%h exp n=1 addr=0 data=9",
                               wa_q.size(), (wa_q.size() > 0) ? wa_q[0] : '1, (wd_q.size() > 0) ? wd_q[0] : '1);
        end
        #1;
        do_abort();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_start_in_load();
        bit ok;
        clear_mon();
        do_start();
        send_byte(8'h00, 0, ok);
        send_byte(8'h00, 0, ok);
        do_start();
        send_byte(8'h00, 0, ok);
        send_byte(8'h01, 0, ok);
        send_byte(8'h02, 0, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (wa_q.size() != 1 || wa_q[0] !== '0 || wd_q[0] !== 36'h0_0000_0102) begin
            errors++; $display("FAIL start_in_load_entry got n=%0d addr=%h data=%h exp n=1 addr=0 data=102",
                               wa_q.size(), (wa_q.size() > 0) ? wa_q[0] : '1, (wd_q.size() > 0) ? wd_q[0] : '1);
        end
        #1;
        send_byte(8'h00, 0, ok);
        send_byte(8'h00, 0, ok);
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_abort_busy got %b exp 0", busy); end
        repeat (3) @(negedge clk);
        checks++; if (wa_q.size() != 1) begin errors++; $display("FAIL start_abort_writes got %0d exp 1", wa_q.size()); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL start_abort_done got %0d exp 0", done_cnt); end
        #1;
    endtask

    initial begin
        test_reset();
        test_full_load("continuous", 1'b0, 1'b0);
        test_upper_nibble();
        test_full_load("gapped", 1'b1, 1'b0);
        test_abort();
        test_start_in_load();
`ifdef FINV_TABLE_CHECKSUM_EN
        test_full_load("bad_csum", 1'b0, 1'b1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
